// File: rtl/uart_tx_cfg_if.sv
// Word handshake between a producer (software, FIFO) and the UART
// transmitter. The producer drives the word and its valid flag; the
// transmitter answers with ready while its holding register is empty.
interface uart_tx_cfg_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;

   // Producer side
   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   // Transmitter side
   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );

endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter. Data length, parity mode, stop-bit
// count and bit period are sampled and clamped at every frame load. A
// one-entry holding register lets the next word be queued while a frame is
// on the line, so consecutive frames leave with no idle clocks between them.
module uart_tx_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1),
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   input  logic [1:0]           cfg_parity,
   input  logic                 cfg_stop2,
   uart_tx_cfg_if.slave         sIf,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]            state_q,     state_d;
   logic                  tx_q,        tx_d;
   logic                  done_q,      done_d;
   logic                  holdValid_q, holdValid_d;
   logic [DATA_WIDTH-1:0] holdData_q,  holdData_d;
   logic [DATA_WIDTH-1:0] shift_q,     shift_d;
   logic [DIV_WIDTH-1:0]  timer_q,     timer_d;
   logic [LEN_WIDTH-1:0]  bitCnt_q,    bitCnt_d;
   logic [DIV_WIDTH-1:0]  divLat_q,    divLat_d;
   logic [LEN_WIDTH-1:0]  lenLat_q,    lenLat_d;
   logic [1:0]            parLat_q,    parLat_d;
   logic                  stop2Lat_q,  stop2Lat_d;
   logic                  parBit_q,    parBit_d;

   logic                  accept;
   logic                  frameLoad;
   logic [DIV_WIDTH-1:0]  divEff;
   logic [LEN_WIDTH-1:0]  lenEff;
   logic [DATA_WIDTH-1:0] lenMask;
   logic [DATA_WIDTH-1:0] maskedData;

   assign accept      = sIf.s_valid && !holdValid_q;
   assign sIf.s_ready = !holdValid_q;
   assign tx          = tx_q;
   assign tx_done     = done_q;
   assign tx_busy     = (state_q != IDLE) || holdValid_q;

   // Clamp the live configuration and mask the held word down to the
   // effective length; these values are only captured at a frame load.
   always_comb begin
      divEff = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
      lenEff = cfg_len;
      if (cfg_len < LEN_WIDTH'(5)) begin
         lenEff = LEN_WIDTH'(5);
      end else if (cfg_len > LEN_WIDTH'(DATA_WIDTH)) begin
         lenEff = LEN_WIDTH'(DATA_WIDTH);
      end
      lenMask = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         lenMask[i] = (LEN_WIDTH'(i) < lenEff);
      end
      maskedData = holdData_q & lenMask;
   end

   // Frame engine: bit timer, bit counter, state sequencing, frame load and
   // holding-register bookkeeping. tx is computed for the bit that starts
   // on the coming edge so the line itself comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
      holdValid_d = holdValid_q;
      holdData_d  = holdData_q;
      shift_d     = shift_q;
      timer_d     = timer_q;
      bitCnt_d    = bitCnt_q;
      divLat_d    = divLat_q;
      lenLat_d    = lenLat_q;
      parLat_d    = parLat_q;
      stop2Lat_d  = stop2Lat_q;
      parBit_d    = parBit_q;
      frameLoad   = 1'b0;

      if (state_q == IDLE) begin
         tx_d      = 1'b1;
         frameLoad = holdValid_q;
      end else if (timer_q != '0) begin
         timer_d = timer_q - DIV_WIDTH'(1);
      end else begin
         timer_d = divLat_q - DIV_WIDTH'(1);
         case (state_q)
            START: begin
               state_d  = DATA;
               tx_d     = shift_q[0];
               bitCnt_d = '0;
            end
            DATA: begin
               if (bitCnt_q == lenLat_q - LEN_WIDTH'(1)) begin
                  bitCnt_d = '0;
                  if (parLat_q != 2'b00) begin
                     state_d = PARITY;
                     tx_d    = parBit_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bitCnt_d = bitCnt_q + LEN_WIDTH'(1);
                  shift_d  = shift_q >> 1;
                  tx_d     = shift_q[1];
               end
            end
            PARITY: begin
               state_d  = STOP;
               tx_d     = 1'b1;
               bitCnt_d = '0;
            end
            STOP: begin
               if (stop2Lat_q && (bitCnt_q == '0)) begin
                  bitCnt_d = LEN_WIDTH'(1);
               end else begin
                  done_d = 1'b1;
                  if (holdValid_q) begin
                     frameLoad = 1'b1;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end

      if (frameLoad) begin
         state_d     = START;
         tx_d        = 1'b0;
         shift_d     = maskedData;
         timer_d     = divEff - DIV_WIDTH'(1);
         bitCnt_d    = '0;
         divLat_d    = divEff;
         lenLat_d    = lenEff;
         parLat_d    = cfg_parity;
         stop2Lat_d  = cfg_stop2;
         holdValid_d = 1'b0;
         case (cfg_parity)
            2'b01:   parBit_d = ^maskedData;
            2'b10:   parBit_d = ~(^maskedData);
            default: parBit_d = 1'b1;
         endcase
      end

      if (accept) begin
         holdValid_d = 1'b1;
         holdData_d  = sIf.s_data;
      end
   end

   // State registers with synchronous active-low reset; a reset mid-frame
   // drops the line high, discards any held word and suppresses tx_done.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
         holdValid_q <= 1'b0;
         holdData_q  <= '0;
         shift_q     <= '0;
         timer_q     <= '0;
         bitCnt_q    <= '0;
         divLat_q    <= DIV_WIDTH'(2);
         lenLat_q    <= LEN_WIDTH'(DATA_WIDTH);
         parLat_q    <= 2'b00;
         stop2Lat_q  <= 1'b0;
         parBit_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
         holdValid_q <= holdValid_d;
         holdData_q  <= holdData_d;
         shift_q     <= shift_d;
         timer_q     <= timer_d;
         bitCnt_q    <= bitCnt_d;
         divLat_q    <= divLat_d;
         lenLat_q    <= lenLat_d;
         parLat_q    <= parLat_d;
         stop2Lat_q  <= stop2Lat_d;
         parBit_q    <= parBit_d;
      end
   end

endmodule
